// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch stage in front of the cpu fetch port.
//   Tracks the cpu PC, prefetches sequential instructions from a pipelined,
//   in-order instruction memory into a DEPTH-entry queue, and presents the
//   instruction for the current PC. Any non-sequential PC flushes the queue.
//   Responses still in flight for the flushed stream are counted and dropped.
//
// Configuration macro:
//   FETCH_BYPASS_EN  when defined, a response for the head entry that matches
//                    the PC is forwarded to the cpu in the same cycle. When
//                    undefined, there is no combinational path from i_mem_*
//                    to o_cpu_*.
//
// Parameters: DEPTH (queue entries / max outstanding, power of 2, >=2),
//             AW (address width), DW (instruction width)
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_cpu_addr          cpu PC
//   o_cpu_inst          instruction for i_cpu_addr, valid when o_cpu_hlt=0
//   o_cpu_hlt           stall, instruction not yet available
//   o_mem_req/o_mem_addr fetch request and address
//   i_mem_gnt           request accepted this cycle when o_mem_req=1
//   i_mem_rvalid/i_mem_rdata  in-order responses, one per accepted request
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_cpu_addr,
  output logic [DW-1:0] o_cpu_inst,
  output logic          o_cpu_hlt,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_gnt,
  input  logic          i_mem_rvalid,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_q_addr [DEPTH];
  logic [DW-1:0] r_q_data [DEPTH];
  logic [DEPTH-1:0] r_q_done;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_resp;   // oldest allocated entry still waiting for data
  logic [CW-1:0] r_cnt;    // allocated entries
  logic [CW-1:0] r_pend;   // allocated entries without data
  logic [CW-1:0] r_drop;   // responses still owed to a flushed stream
  logic [AW-1:0] r_next_addr;
  logic          r_mem_req;
  logic [DW-1:0] r_inst;

  logic          w_empty;
  logic          w_head_match;
  logic          w_head_done;
  logic          w_drop_act;
  logic          w_mismatch;
  logic          w_hit_q;
  logic          w_hit_byp;
  logic          w_hit;
  logic          w_accept;
  logic          w_rv_keep;
  logic          w_rv_drop;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_drop_nxt;
  logic          w_req_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next-count logic
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_drop_nxt = r_drop;
    if (w_mismatch) begin
      // A response arriving in the flush cycle belongs to the old stream:
      // it is already included in r_pend (or r_drop) and consumed now.
      w_cnt_nxt  = '0;
      w_drop_nxt = r_drop + r_pend - CW'(i_mem_rvalid);
    end else begin
      w_cnt_nxt  = r_cnt + CW'(w_accept) - CW'(w_hit);
      w_drop_nxt = r_drop - CW'(w_rv_drop);
    end
    if (w_drop_nxt != '0)     w_state_nxt = S_DRAIN;
    else if (w_cnt_nxt != '0) w_state_nxt = S_RUN;
    else                      w_state_nxt = S_FILL;
    w_req_nxt = ({1'b0, w_cnt_nxt} + {1'b0, w_drop_nxt}) < (CW+1)'(DEPTH);
  end

  // Output / hit / mismatch logic
  always_comb begin
    w_empty      = (r_cnt == '0);
    w_head_match = (r_q_addr[r_head] == i_cpu_addr);
    w_head_done  = r_q_done[r_head];
    w_drop_act   = (r_drop != '0);
    // With an empty queue the stream is defined by next_addr alone.
    w_mismatch   = w_empty ? ((r_state != S_RUN) && (r_next_addr != i_cpu_addr))
                           : !w_head_match;
    w_hit_q      = !w_empty && w_head_match && w_head_done;
`ifdef FETCH_BYPASS_EN
    w_hit_byp    = !w_empty && w_head_match && !w_head_done && i_mem_rvalid && !w_drop_act;
`else
    w_hit_byp    = 1'b0;
`endif
    w_hit        = w_hit_q || w_hit_byp;
    o_cpu_hlt    = !w_hit;
    o_cpu_inst   = r_inst;
    if (w_hit_q) begin
      o_cpu_inst = r_q_data[r_head];
    end
`ifdef FETCH_BYPASS_EN
    else if (w_hit_byp) begin
      o_cpu_inst = i_mem_rdata;
    end
`endif
    // The registered request is masked in a flush cycle so nothing from the
    // old stream is accepted; the redirected request follows next cycle.
    o_mem_req    = r_mem_req && !w_mismatch;
    o_mem_addr   = r_next_addr;
    w_accept     = o_mem_req && i_mem_gnt;
    w_rv_keep    = i_mem_rvalid && !w_drop_act && !w_mismatch;
    w_rv_drop    = i_mem_rvalid && w_drop_act;
  end

  // Queue control and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_resp      <= '0;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_drop      <= '0;
      r_next_addr <= '0;
      r_mem_req   <= 1'b0;
      r_inst      <= '0;
      r_q_done    <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_drop    <= w_drop_nxt;
      r_mem_req <= w_req_nxt;
      if (w_hit) r_inst <= o_cpu_inst;
      if (w_mismatch) begin
        r_head      <= '0;
        r_tail      <= '0;
        r_resp      <= '0;
        r_pend      <= '0;
        r_next_addr <= i_cpu_addr;
      end else begin
        if (w_accept) begin
          r_tail           <= r_tail + PW'(1);
          r_next_addr      <= r_next_addr + AW'(1);
          r_q_done[r_tail] <= 1'b0;
        end
        // A bypassed response also marks its (popped) slot done; the slot is
        // cleared again when it is next allocated.
        if (w_rv_keep) begin
          r_resp           <= r_resp + PW'(1);
          r_q_done[r_resp] <= 1'b1;
        end
        if (w_hit) r_head <= r_head + PW'(1);
        r_pend <= r_pend + CW'(w_accept) - CW'(w_rv_keep);
      end
    end
  end

  // Queue storage (no reset needed: guarded by r_cnt and r_q_done)
  always_ff @(posedge clk) begin
    if (w_accept)  r_q_addr[r_tail] <= r_next_addr;
    if (w_rv_keep) r_q_data[r_resp] <= i_mem_rdata;
  end

endmodule
